sum_ip_v2_axil: RTL and testbench
=================================

Name: sum_ip_v2_axil

Overview:
- AXI4-Lite slave, second-generation summing peripheral.
- Holds NUM_OPERANDS software-written operand registers and sums them sequentially, one operand per clock, into a 32-bit result.
- Supports start/busy/done control, accumulate mode, sticky overflow, interrupt output and SLVERR on illegal accesses.
- Sits behind the PS/master AXI interconnect as a memory-mapped register block.

Parameters:
- NUM_OPERANDS, 8, number of operand registers (2..16).
- OP_WIDTH, 16, stored operand width (1..32); bits above OP_WIDTH are ignored on write and read back 0.
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
- C_S_AXI_ADDR_WIDTH, 7, AXI byte-address width; decode uses bits [C_S_AXI_ADDR_WIDTH-1:2].

Ports:
- ACLK  in  1  single clock, all logic rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- IRQ  out  1  level interrupt, equal to STATUS.DONE & CTRL.IE.

Behaviour:
- Reset: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, IRQ 0; all registers 0; FSM in IDLE.
- Register map:
  - 0x00 CTRL: b0 START, write-1 self-clearing, reads 0; b1 ACC; b2 CLR, W1 clears DONE and OVF; b3 IE.
  - 0x04 STATUS (RO): b0 BUSY, b1 DONE, b2 OVF (sticky).
  - 0x08 RESULT (RO).
  - 0x10+4*i OPERAND[i], i < NUM_OPERANDS.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle only when AWVALID & WVALID & !BVALID.
  - BVALID rises the next cycle and holds until BREADY.
  - WSTRB is honoured per byte on CTRL and OPERAND.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA/RRESP are registered and RVALID rises the next cycle; all three hold until RREADY.
- Responses:
  - Unmapped address: writes discarded with BRESP=SLVERR (2'b10); reads return RDATA=0, RRESP=SLVERR.
  - Write to STATUS/RESULT: SLVERR, no effect.
  - OPERAND write while BUSY: SLVERR, value unchanged.
  - START while BUSY: ignored, OKAY.
- FSM IDLE -> SUM -> IDLE:
  - START write accepted in cycle T loads acc = ACC ? RESULT : 0, clears DONE, sets BUSY at T+1, idx = 0.
  - SUM: each cycle acc += zero-extended OPERAND[idx], idx++. After idx = NUM_OPERANDS-1, RESULT <= acc, BUSY=0 and DONE=1 at T+1+NUM_OPERANDS.
  - Carry out of bit 31 on any add sets OVF (sticky); RESULT wraps modulo 2^32.
- Simultaneous events:
  - CLR and START in the same write: CLR is applied first, then START.
  - Any CTRL write leaves DONE set unless CLR or START is written.
- ARESET mid-SUM: next edge returns to the reset state and discards any outstanding AXI response.

Optional Feature:
- Macro: SUM_IP_SATURATE_EN.
- Defined: an add carrying out of bit 31 clamps acc to 0xFFFFFFFF and holds it there for the remainder of the pass; OVF is still set.
- Undefined: wrap-around modulo 2^32 as above.

Test Plan:
- Reset released, write OPERAND[0..7] = 1..8 at 0x10..0x2C, read back -> 1..8, RRESP=OKAY, STATUS=0.
- Write CTRL=0x9 -> BUSY=1 for exactly 8 cycles, then STATUS=0x2, RESULT=36 (0x24), IRQ=1.
- Write CTRL=0x3 (accumulate) -> RESULT=72. Then write CTRL=0x4 -> STATUS=0, IRQ=0.
- Config OP_WIDTH=32, NUM_OPERANDS=2, operands 0xFFFFFFFF and 0x2, START -> expected result:
  - without macro: RESULT=0x1, OVF=1;
  - with SUM_IP_SATURATE_EN: RESULT=0xFFFFFFFF, OVF=1.
- Illegal accesses:
  - write 0x7C -> BRESP=SLVERR;
  - read 0x7C -> RDATA=0, RRESP=SLVERR;
  - write OPERAND[0]=0x55 during BUSY -> BRESP=SLVERR, readback unchanged.
- Stall and reset:
  - hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and data stable throughout;
  - assert ARESET mid-SUM -> next cycle all outputs 0, operands 0, STATUS=0.

Source files
------------

// File: rtl/sum_ip_v2_axil_if.sv
// AXI4-Lite bus bundle for sum_ip_v2_axil.
// The slave modport is used by the peripheral and the master modport by the driving side.
interface sum_ip_v2_axil_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/sum_ip_v2_axil.sv
// AXI4-Lite summing peripheral: NUM_OPERANDS operand registers are added one per clock into RESULT.
// Define SUM_IP_SATURATE_EN to clamp the accumulator at 0xFFFFFFFF on overflow instead of wrapping.
module sum_ip_v2_axil #(
    parameter int NUM_OPERANDS       = 8,
    parameter int OP_WIDTH           = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic            ACLK,
    input  logic            ARESET,
    sum_ip_v2_axil_if.slave s_axi,
    output logic            IRQ
);
    localparam int IDX_W = $clog2(NUM_OPERANDS);
    localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SUM  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [WA_W-1:0] W_CTRL   = WA_W'(0);
    localparam logic [WA_W-1:0] W_STATUS = WA_W'(1);
    localparam logic [WA_W-1:0] W_RESULT = WA_W'(2);
    localparam logic [WA_W-1:0] W_OP_LO  = WA_W'(4);

    logic [OP_WIDTH-1:0]           r_op [NUM_OPERANDS];
    logic [0:0]                    r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [31:0]                   r_acc;
    logic [31:0]                   r_result;
    logic                          r_acc_mode;
    logic                          r_ie;
    logic                          r_done;
    logic                          r_ovf;
    logic                          r_awready;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [WA_W-1:0]         w_wr_word;
    logic [WA_W-1:0]         w_rd_word;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic                    w_busy;
    logic                    w_ctrl_wr;
    logic                    w_start;
    logic                    w_clr;
    logic                    w_last;
    logic                    w_carry;
    logic [NUM_OPERANDS-1:0] w_wr_op_sel;
    logic [31:0]             w_wmask;
    logic [31:0]             w_sum;
    logic [31:0]             w_next;
    logic [31:0]             w_rd_data;
    logic [1:0]              w_wr_resp;
    logic [1:0]              w_rd_resp;
    logic                    w_unused;

    assign w_wr_word = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_word = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_en   = r_awready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign w_rd_en   = r_arready & s_axi.S_AXI_ARVALID;
    assign w_busy    = (r_state == S_SUM);
    assign w_ctrl_wr = w_wr_en && (w_wr_word == W_CTRL) && s_axi.S_AXI_WSTRB[0];
    assign w_start   = w_ctrl_wr & s_axi.S_AXI_WDATA[0];
    assign w_clr     = w_ctrl_wr & s_axi.S_AXI_WDATA[2];
    assign w_last    = (r_idx == IDX_W'(NUM_OPERANDS - 1));
    assign w_unused  = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, 32'(r_op[r_idx])};
`ifdef SUM_IP_SATURATE_EN
    // Once clamped, every later add either carries again or adds zero, so the clamp holds.
    assign w_next = w_carry ? 32'hFFFF_FFFF : w_sum;
`else
    assign w_next = w_sum;
`endif

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_wmask[8*b +: 8] = {8{s_axi.S_AXI_WSTRB[b]}};
        end
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            w_wr_op_sel[i] = (w_wr_word == W_OP_LO + WA_W'(i));
        end
    end

    always_comb begin
        w_wr_resp = RESP_SLVERR;
        if (w_wr_word == W_CTRL) begin
            w_wr_resp = RESP_OKAY;
        end else if ((|w_wr_op_sel) && !w_busy) begin
            w_wr_resp = RESP_OKAY;
        end
    end

    always_comb begin
        w_rd_data = 32'h0;
        w_rd_resp = RESP_SLVERR;
        if (w_rd_word == W_CTRL) begin
            w_rd_data = {28'h0, r_ie, 1'b0, r_acc_mode, 1'b0};
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_word == W_STATUS) begin
            w_rd_data = {29'h0, r_ovf, r_done, w_busy};
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_word == W_RESULT) begin
            w_rd_data = r_result;
            w_rd_resp = RESP_OKAY;
        end
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (w_rd_word == W_OP_LO + WA_W'(i)) begin
                w_rd_data = 32'(r_op[i]);
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (w_wr_en && w_wr_op_sel[i] && !w_busy) begin
                    r_op[i] <= OP_WIDTH'((32'(r_op[i]) & ~w_wmask) | (s_axi.S_AXI_WDATA & w_wmask));
                end
            end
        end
    end

    // Later assignments win: a pass finishing in the same cycle as CLR still reports DONE/OVF.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_acc      <= 32'h0;
            r_result   <= 32'h0;
            r_acc_mode <= 1'b0;
            r_ie       <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_acc_mode <= s_axi.S_AXI_WDATA[1];
                r_ie       <= s_axi.S_AXI_WDATA[3];
            end
            if (w_clr) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_acc   <= s_axi.S_AXI_WDATA[1] ? r_result : 32'h0;
                        r_done  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_SUM;
                    end
                end
                default: begin
                    r_acc <= w_next;
                    r_idx <= r_idx + 1'b1;
                    if (w_carry) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_last) begin
                        r_result <= w_next;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_awready <= !r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_resp;
            end else if (s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= !r_arready && s_axi.S_AXI_ARVALID && !r_rvalid;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign IRQ                 = r_done & r_ie;
endmodule

// File: tb/tb_sum_ip_v2_axil.sv
// Directed bench: dut_a uses default parameters, dut_b is the 2 x 32-bit overflow configuration.
// Read expectations go through a scoreboard queue and are popped when RVALID appears.
module tb_sum_ip_v2_axil;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;
    int hs_cyc = 0;

    logic        sel;
    logic [6:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        irq_a, irq_b;

    logic [31:0] q_data[$];
    logic [1:0]  q_resp[$];

    sum_ip_v2_axil_if #(.C_S_AXI_ADDR_WIDTH(7)) ifa ();
    sum_ip_v2_axil_if #(.C_S_AXI_ADDR_WIDTH(7)) ifb ();

    assign ifa.S_AXI_AWADDR  = awaddr;
    assign ifa.S_AXI_WDATA   = wdata;
    assign ifa.S_AXI_WSTRB   = wstrb;
    assign ifa.S_AXI_ARADDR  = araddr;
    assign ifa.S_AXI_AWVALID = awvalid & ~sel;
    assign ifa.S_AXI_WVALID  = wvalid & ~sel;
    assign ifa.S_AXI_BREADY  = bready & ~sel;
    assign ifa.S_AXI_ARVALID = arvalid & ~sel;
    assign ifa.S_AXI_RREADY  = rready & ~sel;
    assign ifb.S_AXI_AWADDR  = awaddr;
    assign ifb.S_AXI_WDATA   = wdata;
    assign ifb.S_AXI_WSTRB   = wstrb;
    assign ifb.S_AXI_ARADDR  = araddr;
    assign ifb.S_AXI_AWVALID = awvalid & sel;
    assign ifb.S_AXI_WVALID  = wvalid & sel;
    assign ifb.S_AXI_BREADY  = bready & sel;
    assign ifb.S_AXI_ARVALID = arvalid & sel;
    assign ifb.S_AXI_RREADY  = rready & sel;

    wire        w_awready = sel ? ifb.S_AXI_AWREADY : ifa.S_AXI_AWREADY;
    wire        w_wready  = sel ? ifb.S_AXI_WREADY  : ifa.S_AXI_WREADY;
    wire        w_bvalid  = sel ? ifb.S_AXI_BVALID  : ifa.S_AXI_BVALID;
    wire [1:0]  w_bresp   = sel ? ifb.S_AXI_BRESP   : ifa.S_AXI_BRESP;
    wire        w_arready = sel ? ifb.S_AXI_ARREADY : ifa.S_AXI_ARREADY;
    wire        w_rvalid  = sel ? ifb.S_AXI_RVALID  : ifa.S_AXI_RVALID;
    wire [31:0] w_rdata   = sel ? ifb.S_AXI_RDATA   : ifa.S_AXI_RDATA;
    wire [1:0]  w_rresp   = sel ? ifb.S_AXI_RRESP   : ifa.S_AXI_RRESP;
    wire        w_irq     = sel ? irq_b : irq_a;

    sum_ip_v2_axil dut_a (.ACLK(clk), .ARESET(rst), .s_axi(ifa), .IRQ(irq_a));
    sum_ip_v2_axil #(.NUM_OPERANDS(2), .OP_WIDTH(32)) dut_b (
        .ACLK(clk), .ARESET(rst), .s_axi(ifb), .IRQ(irq_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_resp, input int stall, input string tag);
        int n;
        logic ok;
        logic [1:0] r0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!w_awready && n < 20) begin tick(1); n++; end
        chk({tag, "_awready"}, 32'(w_awready & w_wready), 32'd1);
        tick(1);
        hs_cyc = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!w_bvalid && n < 20) begin tick(1); n++; end
        if (stall > 0) begin
            ok = 1'b1;
            r0 = w_bresp;
            repeat (stall) begin
                tick(1);
                if (!w_bvalid || w_bresp !== r0) ok = 1'b0;
            end
            chk({tag, "_bstall"}, 32'(ok), 32'd1);
        end
        bready = 1'b1;
        chk({tag, "_bresp"}, {29'h0, w_bvalid, w_bresp}, {29'h0, 1'b1, exp_resp});
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                            input int stall, input string tag);
        int n;
        logic ok;
        logic [31:0] d0, ed;
        logic [1:0] er;
        q_data.push_back(exp_d);
        q_resp.push_back(exp_r);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!w_arready && n < 20) begin tick(1); n++; end
        tick(1);
        arvalid = 1'b0;
        n = 0;
        while (!w_rvalid && n < 20) begin tick(1); n++; end
        chk({tag, "_rvalid"}, 32'(w_rvalid), 32'd1);
        if (stall > 0) begin
            ok = 1'b1;
            d0 = w_rdata;
            repeat (stall) begin
                tick(1);
                if (!w_rvalid || w_rdata !== d0) ok = 1'b0;
            end
            chk({tag, "_rstall"}, 32'(ok), 32'd1);
        end
        rready = 1'b1;
        ed = q_data.pop_front();
        er = q_resp.pop_front();
        chk({tag, "_rdata"}, w_rdata, ed);
        chk({tag, "_rresp"}, 32'(w_rresp), 32'(er));
        tick(1);
        rready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; sel = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        tick(3);
        chk("reset_outs_a", {23'h0, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID,
            ifa.S_AXI_BRESP, ifa.S_AXI_ARREADY, ifa.S_AXI_RVALID, ifa.S_AXI_RRESP, irq_a}, 32'h0);
        chk("reset_rdata_a", ifa.S_AXI_RDATA, 32'h0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) axi_write(7'(16 + 4*i), 32'(i + 1), 4'hF, 2'b00, 0, "op_wr");
        for (int i = 0; i < 8; i++) axi_read(7'(16 + 4*i), 32'(i + 1), 2'b00, 0, "op_rd");
        axi_read(7'h04, 32'h0, 2'b00, 0, "status_init");

        axi_write(7'h00, 32'h9, 4'hF, 2'b00, 0, "start_ie");
        n = 0;
        while (!w_irq && n < 30) begin tick(1); n++; end
        chk("busy_cycles", 32'(cyc - hs_cyc), 32'd8);
        chk("irq_done", 32'(w_irq), 32'd1);
        axi_read(7'h04, 32'h2, 2'b00, 0, "status_done");
        axi_read(7'h08, 32'd36, 2'b00, 0, "result_36");

        axi_write(7'h00, 32'h3, 4'hF, 2'b00, 0, "start_acc");
        tick(12);
        axi_read(7'h08, 32'd72, 2'b00, 0, "result_72");
        axi_read(7'h04, 32'h2, 2'b00, 0, "status_acc");
        chk("irq_ie_off", 32'(w_irq), 32'd0);
        axi_write(7'h00, 32'h8, 4'hF, 2'b00, 0, "ctrl_ie");
        chk("irq_done_kept", 32'(w_irq), 32'd1);
        axi_read(7'h00, 32'h8, 2'b00, 0, "ctrl_rd");
        axi_write(7'h00, 32'h4, 4'hF, 2'b00, 0, "ctrl_clr");
        axi_read(7'h04, 32'h0, 2'b00, 0, "status_clr");
        chk("irq_clr", 32'(w_irq), 32'd0);

        axi_write(7'h14, 32'hABCD_1234, 4'hF, 2'b00, 0, "op1_wide");
        axi_read(7'h14, 32'h0000_1234, 2'b00, 0, "op1_trunc");
        axi_write(7'h14, 32'h0000_0099, 4'h1, 2'b00, 0, "op1_strb");
        axi_read(7'h14, 32'h0000_1299, 2'b00, 0, "op1_byte");
        axi_write(7'h14, 32'h2, 4'hF, 2'b00, 0, "op1_restore");

        axi_write(7'h7C, 32'h1234, 4'hF, 2'b10, 0, "wr_unmapped");
        axi_read(7'h7C, 32'h0, 2'b10, 0, "rd_unmapped");
        axi_read(7'h0C, 32'h0, 2'b10, 0, "rd_gap");
        axi_write(7'h04, 32'h7, 4'hF, 2'b10, 0, "wr_status");
        axi_write(7'h08, 32'h5, 4'hF, 2'b10, 0, "wr_result");
        axi_read(7'h08, 32'd72, 2'b00, 0, "result_kept");

        axi_write(7'h00, 32'h1, 4'hF, 2'b00, 0, "start_busy");
        axi_write(7'h10, 32'h55, 4'hF, 2'b10, 0, "op_wr_busy");
        axi_write(7'h00, 32'h1, 4'hF, 2'b00, 0, "start_again");
        tick(12);
        axi_read(7'h10, 32'h1, 2'b00, 0, "op0_kept");
        axi_read(7'h08, 32'd36, 2'b00, 0, "result_rerun");
        axi_read(7'h04, 32'h2, 2'b00, 0, "status_rerun");

        axi_write(7'h18, 32'h3, 4'hF, 2'b00, 10, "b_stall");
        axi_read(7'h18, 32'h3, 2'b00, 10, "r_stall");

        axi_write(7'h00, 32'h9, 4'hF, 2'b00, 0, "start_rst");
        araddr = 7'h08; arvalid = 1'b1;
        n = 0;
        while (!w_rvalid && n < 10) begin tick(1); n++; end
        arvalid = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("midsum_outs", {23'h0, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_BVALID,
            ifa.S_AXI_BRESP, ifa.S_AXI_ARREADY, ifa.S_AXI_RVALID, ifa.S_AXI_RRESP, irq_a}, 32'h0);
        chk("midsum_rdata", ifa.S_AXI_RDATA, 32'h0);
        rst = 1'b0;
        tick(1);
        axi_read(7'h10, 32'h0, 2'b00, 0, "op0_rst");
        axi_read(7'h04, 32'h0, 2'b00, 0, "status_rst");
        axi_read(7'h08, 32'h0, 2'b00, 0, "result_rst");

        sel = 1'b1;
        tick(1);
        axi_write(7'h10, 32'hFFFF_FFFF, 4'hF, 2'b00, 0, "b_op0");
        axi_write(7'h14, 32'h2, 4'hF, 2'b00, 0, "b_op1");
        axi_write(7'h18, 32'h9, 4'hF, 2'b10, 0, "b_op2_unmapped");
        axi_write(7'h00, 32'h1, 4'hF, 2'b00, 0, "b_start");
        tick(6);
`ifdef SUM_IP_SATURATE_EN
        axi_read(7'h08, 32'hFFFF_FFFF, 2'b00, 0, "b_result_sat");
`else
        axi_read(7'h08, 32'h0000_0001, 2'b00, 0, "b_result_wrap");
`endif
        axi_read(7'h04, 32'h6, 2'b00, 0, "b_status_ovf");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
